// File: rtl/div_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : div_bcd_conv
// Description : Converts a divider's binary quotient and remainder to packed
//               BCD with a double-dabble (shift-and-add-3) engine. A conversion
//               is triggered by the rising edge of divEnd. Both operands run
//               through two engines in parallel, with a fixed latency.
// Ports       : clk    - single clock, all state changes on posedge
//               rst    - synchronous active-high reset
//               divEnd - divider-finished level
//               quoc   - binary quotient  (N_BITS)
//               rest   - binary remainder (N_BITS)
//               bcd_q  - packed BCD quotient, MS digit in the MSBs (4*N_DIG)
//               bcd_r  - packed BCD remainder, same packing (4*N_DIG)
//               busy   - high while in ADJUST or SHIFT
//               done   - one-cycle pulse when the results are valid
//               state  - current state code, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module div_bcd_conv #(
  parameter int N_BITS = 8,
  parameter int N_DIG  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 divEnd,
  input  logic [N_BITS-1:0]    quoc,
  input  logic [N_BITS-1:0]    rest,
  output logic [4*N_DIG-1:0]   bcd_q,
  output logic [4*N_DIG-1:0]   bcd_r,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state
);

  localparam int c_BCD_W = 4 * N_DIG;
  localparam int c_DD_W  = c_BCD_W + N_BITS;
  localparam int c_CNT_W = $clog2(N_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_ADJUST = 3'b001,
    S_SHIFT  = 3'b010,
    S_DONE   = 3'b011
  } state_t;

  state_t               r_state;
  logic                 r_divEnd_d;
  logic [c_CNT_W-1:0]   r_cnt;
  // Double-dabble working registers: {BCD field, binary field}
  logic [c_DD_W-1:0]    r_dd_q;
  logic [c_DD_W-1:0]    r_dd_r;
  logic [c_BCD_W-1:0]   r_bcd_q;
  logic [c_BCD_W-1:0]   r_bcd_r;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_start;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic [c_DD_W-1:0]    w_adj_q;
  logic [c_DD_W-1:0]    w_adj_r;
  logic [c_DD_W-1:0]    w_shl_q;
  logic [c_DD_W-1:0]    w_shl_r;

  // divEnd_d is preset to 1 on reset so a level already high does not start
  assign w_start   = divEnd & ~r_divEnd_d;
  assign w_cnt_nxt = r_cnt + c_CNT_W'(1);
  assign w_shl_q   = {r_dd_q[c_DD_W-2:0], 1'b0};
  assign w_shl_r   = {r_dd_r[c_DD_W-2:0], 1'b0};

  // Add-3 correction on every BCD nibble >= 5, both engines in parallel
  assign w_adj_q[N_BITS-1:0] = r_dd_q[N_BITS-1:0];
  assign w_adj_r[N_BITS-1:0] = r_dd_r[N_BITS-1:0];
  for (genvar i = 0; i < N_DIG; i++) begin : g_nib
    assign w_adj_q[N_BITS+4*i +: 4] = (r_dd_q[N_BITS+4*i +: 4] >= 4'd5) ?
                                      r_dd_q[N_BITS+4*i +: 4] + 4'd3 :
                                      r_dd_q[N_BITS+4*i +: 4];
    assign w_adj_r[N_BITS+4*i +: 4] = (r_dd_r[N_BITS+4*i +: 4] >= 4'd5) ?
                                      r_dd_r[N_BITS+4*i +: 4] + 4'd3 :
                                      r_dd_r[N_BITS+4*i +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_divEnd_d <= 1'b1;
      r_cnt      <= '0;
      r_dd_q     <= '0;
      r_dd_r     <= '0;
      r_bcd_q    <= '0;
      r_bcd_r    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_divEnd_d <= divEnd;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dd_q  <= {{c_BCD_W{1'b0}}, quoc};
            r_dd_r  <= {{c_BCD_W{1'b0}}, rest};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADJUST;
          end
        end
        S_ADJUST: begin
          r_dd_q  <= w_adj_q;
          r_dd_r  <= w_adj_r;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_dd_q <= w_shl_q;
          r_dd_r <= w_shl_r;
          r_cnt  <= w_cnt_nxt;
          if (w_cnt_nxt == c_CNT_W'(N_BITS)) begin
            r_bcd_q <= w_shl_q[c_DD_W-1 -: c_BCD_W];
            r_bcd_r <= w_shl_r[c_DD_W-1 -: c_BCD_W];
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADJUST;
          end
        end
        S_DONE: begin
          // Pulse is registered, so it appears the cycle after DONE
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bcd_q = r_bcd_q;
  assign bcd_r = r_bcd_r;
  assign busy  = r_busy;
  assign done  = r_done;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_div_bcd_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_bcd_conv
// Description : Directed self-checking bench for div_bcd_conv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        divEnd;
  logic [7:0]  quoc;
  logic [7:0]  rest;
  logic [11:0] bcd_q;
  logic [11:0] bcd_r;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_bcd_conv #(.N_BITS(8), .N_DIG(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .divEnd(divEnd),
    .quoc  (quoc),
    .rest  (rest),
    .bcd_q (bcd_q),
    .bcd_r (bcd_r),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Fresh divEnd rise; returns edges from capture to done and busy cycle count
  task automatic run_conv(input logic [7:0] q, input logic [7:0] r,
                          output int lat, output int busy_n);
    divEnd = 1'b0;
    step();
    quoc   = q;
    rest   = r;
    divEnd = 1'b1;
    step();
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (busy) busy_n++;
    end
  endtask

  initial begin
    int lat, bn, pulses, busy_seen;

    rst = 1'b1; divEnd = 1'b0; quoc = '0; rest = '0;
    repeat (2) step();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_bcd_q", 32'(bcd_q), 32'h0);
    chk("rst_bcd_r", 32'(bcd_r), 32'h0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    rst = 1'b0;
    step();

    // 17 / 3
    run_conv(8'd17, 8'd3, lat, bn);
    chk("c17_latency", 32'(lat), 32'd17);
    chk("c17_busy_cycles", 32'(bn), 32'd16);
    chk("c17_bcd_q", 32'(bcd_q), 32'h017);
    chk("c17_bcd_r", 32'(bcd_r), 32'h003);
    chk("c17_state_after", 32'(state), 32'd0);
    step();
    chk("c17_done_one_cycle", 32'(done), 32'd0);

    // Boundaries
    run_conv(8'd255, 8'd0, lat, bn);
    chk("c255_bcd_q", 32'(bcd_q), 32'h255);
    chk("c255_bcd_r", 32'(bcd_r), 32'h000);
    run_conv(8'd0, 8'd0, lat, bn);
    chk("c0_bcd_q", 32'(bcd_q), 32'h000);
    chk("c0_bcd_r", 32'(bcd_r), 32'h000);

    // divEnd held high 60 cycles -> one conversion
    divEnd = 1'b0;
    step();
    quoc = 8'd50; rest = 8'd6; divEnd = 1'b1;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done) pulses++;
    end
    chk("held_pulses", 32'(pulses), 32'd1);
    chk("held_bcd_q", 32'(bcd_q), 32'h050);
    run_conv(8'd201, 8'd99, lat, bn);
    chk("rearm_latency", 32'(lat), 32'd17);
    chk("rearm_bcd_q", 32'(bcd_q), 32'h201);
    chk("rearm_bcd_r", 32'(bcd_r), 32'h099);

    // Reset at cycle 5 of a conversion, divEnd held high across it
    divEnd = 1'b0;
    step();
    quoc = 8'd200; rest = 8'd100; divEnd = 1'b1;
    step();
    repeat (4) step();
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_bcd_q", 32'(bcd_q), 32'h0);
    chk("mid_rst_bcd_r", 32'(bcd_r), 32'h0);
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_done",  32'(done),  32'd0);
    pulses = 0; busy_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    chk("post_rst_no_done", 32'(pulses), 32'd0);
    chk("post_rst_no_busy", 32'(busy_seen), 32'd0);
    run_conv(8'd123, 8'd45, lat, bn);
    chk("fresh_bcd_q", 32'(bcd_q), 32'h123);
    chk("fresh_bcd_r", 32'(bcd_r), 32'h045);

    // Reset wins over a start in the same cycle
    divEnd = 1'b0;
    step();
    divEnd = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_vs_start_state", 32'(state), 32'd0);
    repeat (3) step();
    chk("rst_vs_start_idle", 32'(state), 32'd0);
    chk("rst_vs_start_bcd", 32'(bcd_q), 32'h0);
    run_conv(8'd123, 8'd45, lat, bn);
    chk("restore_bcd_q", 32'(bcd_q), 32'h123);

    // Operand change after capture, plus an extra divEnd rise while busy
    divEnd = 1'b0;
    step();
    quoc = 8'd99; rest = 8'd7; divEnd = 1'b1;
    step();
    step();
    step();
    quoc = 8'd42; rest = 8'd88;
    chk("hold_during_conv", 32'(bcd_q), 32'h123);
    divEnd = 1'b0;
    step();
    divEnd = 1'b1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (done) pulses++;
    end
    chk("ignored_rise_pulses", 32'(pulses), 32'd1);
    chk("late_change_bcd_q", 32'(bcd_q), 32'h099);
    chk("late_change_bcd_r", 32'(bcd_r), 32'h007);

    // Sweep every operand value through both engines
    for (int i = 0; i < 256; i++) begin
      run_conv(8'(i), 8'(255 - i), lat, bn);
      chk($sformatf("sweep_q_%0d", i), 32'(bcd_q), 32'(ref_bcd(i)));
      chk($sformatf("sweep_r_%0d", 255 - i), 32'(bcd_r), 32'(ref_bcd(255 - i)));
      if (i % 64 == 0) chk($sformatf("sweep_lat_%0d", i), 32'(lat), 32'd17);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
